// File: rtl/period_meter.sv
// rtl/period_meter.sv - millisecond period measurement of an asynchronous pulse input
module period_meter #(
  parameter int TICKS_PER_MS = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pulse_in,
  output logic [15:0] period,
  output logic        period_valid,
  output logic        overflow,
  output logic        busy
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_ARMED   = 2'd1;
  localparam logic [1:0]  ST_MEASURE = 2'd2;
  localparam logic [16:0] SUB_LAST   = 17'(TICKS_PER_MS - 1);
  localparam logic [15:0] MS_MAX     = 16'hFFFF;

  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic [1:0]  r_state;
  logic [16:0] r_sub;
  logic [15:0] r_ms;
  logic [15:0] r_period;
  logic        r_valid;
  logic        r_overflow;
  logic        r_busy;

  logic        w_rise;
  logic        w_sub_wrap;
  logic        w_sat;

  // s2 is the synchronized level, s3 its previous value; a 0->1 step is one edge
  assign w_rise     = r_s2 & ~r_s3;
  assign w_sub_wrap = (r_sub == SUB_LAST);
  // Last tick of the 0xFFFF-th millisecond: no room left to count further
  assign w_sat      = w_sub_wrap && (r_ms == MS_MAX);

  assign period       = r_period;
  assign period_valid = r_valid;
  assign overflow     = r_overflow;
  assign busy         = r_busy;

  // Two-flop synchronizer plus history flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pulse_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Control FSM, millisecond counters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sub      <= '0;
      r_ms       <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!enable) begin
        // Disable wins over any edge; results are kept for the consumer
        r_state <= ST_IDLE;
        r_sub   <= '0;
        r_ms    <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ARMED;
            r_sub   <= '0;
            r_ms    <= '0;
            r_busy  <= 1'b0;
          end
          ST_ARMED: begin
            r_sub <= '0;
            r_ms  <= '0;
            if (w_rise) begin
              r_state <= ST_MEASURE;
              r_busy  <= 1'b1;
            end
          end
          ST_MEASURE: begin
            if (w_rise) begin
              // An edge on the saturation tick still reports a normal result
              r_period   <= r_ms;
              r_overflow <= 1'b0;
              r_valid    <= 1'b1;
              r_sub      <= '0;
              r_ms       <= '0;
            end else if (w_sat) begin
              // Give up on this interval; the next edge starts a fresh one
              r_period   <= MS_MAX;
              r_overflow <= 1'b1;
              r_valid    <= 1'b1;
              r_sub      <= '0;
              r_ms       <= '0;
              r_state    <= ST_ARMED;
              r_busy     <= 1'b0;
            end else if (w_sub_wrap) begin
              r_sub <= '0;
              r_ms  <= r_ms + 16'd1;
            end else begin
              r_sub <= r_sub + 17'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_sub   <= '0;
            r_ms    <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the interval between successive rising edges of an asynchronous pulse input in whole milliseconds, using the 100 MHz system clock. It pairs with the periodic tick generator: that block turns a period into a pulse train, and this block turns a pulse train back into a period. It sits between external sensor or test inputs and the display/control logic, which consume `period` when `period_valid` strobes.

## Interface
- `TICKS_PER_MS`, default 100_000: clk cycles per millisecond. Range 2..131071, held in a 17-bit prescaler.
- `clk` input, 1 bit: system clock, 100 MHz. All logic is on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high. It is sampled only on a `clk` rising edge.
- `enable` input, 1 bit: measurement enable. When low, the block is forced to IDLE.
- `pulse_in` input, 1 bit: asynchronous pulse source. Only rising edges are measured.
- `period` output, 16 bits: last measured interval in ms (floor). Held until the next result.
- `period_valid` output, 1 bit: one-cycle strobe, asserted in the same cycle `period` and `overflow` update.
- `overflow` output, 1 bit: set when the last result saturated at 0xFFFF ms.
- `busy` output, 1 bit: high while in MEASURE.

## Operation
- Synchronizer: `pulse_in` passes through 2 flops (s1, s2), plus a history flop s3.
  - `rise` = s2 & ~s3.
  - `rise` is never high in two consecutive cycles.
- Prescaler `sub` (17 bits) counts 0..TICKS_PER_MS-1.
  - On wrap, `ms_cnt` (16 bits) increments.
  - Both counters clear on any accepted `rise`, on entry to IDLE, and on reset.
- States are IDLE, ARMED and MEASURE. Reset state is IDLE.
  - IDLE: counters held at 0. `enable`=1 -> ARMED on the next cycle.
  - ARMED: waits for the first edge, and counters are held at 0. `rise` -> MEASURE, with counting starting from 0 in the next cycle.
  - MEASURE, on `rise`:
    - `period` <= `ms_cnt`, `overflow` <= 0, `period_valid` <= 1.
    - Counters restart from 0 and the state stays in MEASURE.
  - MEASURE, when `ms_cnt`=0xFFFF and `sub`=TICKS_PER_MS-1 with no `rise`:
    - `period` <= 0xFFFF, `overflow` <= 1, `period_valid` <= 1.
    - Counters clear and the state goes to ARMED. The next edge is treated as a first edge.
  - Any state with `enable`=0: IDLE on the next cycle, counters cleared. `period` and `overflow` keep their last values.
- Simultaneous events:
  - `enable`=0 beats `rise`: no result is produced.
  - `rise` beats saturation in the same cycle: the normal result is `period`=0xFFFF with `overflow`=0.
- An interval shorter than 1 ms yields `period`=0, which is a valid result.
- Arithmetic is unsigned. `ms_cnt` never wraps; it saturates via the overflow path.

## Timing
- Reset values: `period`=0, `period_valid`=0, `overflow`=0, `busy`=0. All internal flops are 0.
- Input latency: `pulse_in` sampled high at edge N gives `rise`=1 during cycle N+2.
- Output latency: `period_valid` is registered and high in cycle N+3. It is exactly one cycle wide.
- Measured value: with rises at cycles A and B (B > A), `period` = floor((B-A-1)/TICKS_PER_MS), saturating at 0xFFFF.
- `busy` is registered from the state. It rises the cycle after the first accepted `rise` and falls the cycle after leaving MEASURE.
- Reset mid-measurement: the next cycle shows all reset values. No `period_valid` is emitted.
- Minimum resolvable edge spacing is 2 cycles. Narrower input pulses may be missed.

## Test plan
Simulation uses `TICKS_PER_MS`=10.
- Reset and first edge:
  - Stimulus: assert `rst` 2 cycles, then `enable`=1, then one `pulse_in` rise.
  - Required: all outputs 0, `busy` goes 1, no `period_valid` after the first edge.
- Normal interval:
  - Stimulus: with `enable`=1, `rise` events spaced 51 cycles apart.
  - Required: `period`=5, `overflow`=0, `period_valid` is one cycle wide.
- Sub-ms and boundary:
  - Stimulus: rises spaced 10 cycles apart, then spaced 11 cycles apart.
  - Required: first result `period`=0, second `period`=1.
- Saturation:
  - Stimulus: hold with no second edge for 65535×10+10 cycles.
  - Required: `period`=0xFFFF, `overflow`=1, a single `period_valid`, `busy` goes 0 (ARMED).
  - Then a rise followed by a rise 31 cycles later: `period`=3, `overflow`=0.
- `enable` drop:
  - Stimulus: deassert `enable` mid-MEASURE in the same cycle as a `rise`.
  - Required: no `period_valid`, `period` unchanged, IDLE, `busy`=0.
- Reset mid-measurement:
  - Stimulus: assert `rst` one cycle during MEASURE.
  - Required: next cycle `period`=0, `overflow`=0, `busy`=0.
  - A following rise only re-arms (requires `enable`), with no spurious result.
